// File: rtl/fetch_if.sv
// Fetch-side bundle: instruction memory handshake plus decode valid/stall and
// the control-flow event strobes.
interface fetch_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        instr_valid;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic        stall;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        trap;
  logic [31:0] pc_out;

  modport master (
    output imem_req, imem_addr, instr_valid, instr, instr_pc, pc_out,
    input  imem_ack, imem_rdata, stall, redirect, redirect_pc, trap
  );

  modport slave (
    input  imem_req, imem_addr, instr_valid, instr, instr_pc, pc_out,
    output imem_ack, imem_rdata, stall, redirect, redirect_pc, trap
  );
endinterface

// File: rtl/fetch_controller.sv
// Instruction-fetch sequencer: owns the PC, runs the imem req/ack handshake and
// hands fetched words to decode. In-flight requests always complete; redirects are parked.
module fetch_controller #(
  parameter logic [31:0] RESET_PC    = 32'h0000_0000,
  parameter logic [31:0] TRAP_VECTOR = 32'h0000_0100
) (
  input logic    clk,
  input logic    reset_n,
  fetch_if.master bus
);

  typedef enum logic [1:0] {IDLE, REQ, VALID} state_t;

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic        pend_q, pend_d;
  logic [31:0] pend_pc_q, pend_pc_d;
  logic [31:0] instr_q, instr_d;
  logic [31:0] instr_pc_q, instr_pc_d;

  logic        ev;
  logic [31:0] target;

  assign ev     = bus.trap | bus.redirect;
  assign target = bus.trap ? TRAP_VECTOR : {bus.redirect_pc[31:2], 2'b00};

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      pc_q       <= RESET_PC;
      pend_q     <= 1'b0;
      pend_pc_q  <= 32'h0;
      instr_q    <= 32'h0;
      instr_pc_q <= 32'h0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      pend_q     <= pend_d;
      pend_pc_q  <= pend_pc_d;
      instr_q    <= instr_d;
      instr_pc_q <= instr_pc_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    pend_d     = pend_q;
    pend_pc_d  = pend_pc_q;
    instr_d    = instr_q;
    instr_pc_d = instr_pc_q;
    unique case (state_q)
      IDLE: begin
        state_d = REQ;
        if (ev) pc_d = target;
      end
      REQ: begin
        if (bus.imem_ack) begin
          if (ev || pend_q) begin
            // Response belongs to the old stream: drop it and refetch.
            pc_d   = ev ? target : pend_pc_q;
            pend_d = 1'b0;
          end else begin
            instr_d    = bus.imem_rdata;
            instr_pc_d = pc_q;
            pc_d       = pc_q + 32'd4;
            state_d    = VALID;
          end
        end else if (ev) begin
          // Address must stay stable until ack, so park the newest target.
          pend_d    = 1'b1;
          pend_pc_d = target;
        end
      end
      VALID: begin
        if (ev) begin
          pc_d    = target;
          state_d = REQ;
        end else if (!bus.stall) begin
          state_d = REQ;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.imem_req    = (state_q == REQ);
  assign bus.instr_valid = (state_q == VALID);
  assign bus.imem_addr   = pc_q;
  assign bus.pc_out      = pc_q;
  assign bus.instr       = instr_q;
  assign bus.instr_pc    = instr_pc_q;

endmodule

// File: tb/tb_fetch_controller.sv
// Directed bench for fetch_controller: inputs change and outputs are checked on
// the falling edge, one step per cycle.
module tb_fetch_controller;

  logic clk;
  logic reset_n;
  int   checks;
  int   errors;

  fetch_if bus();

  fetch_controller #(
    .RESET_PC    (32'h0000_0000),
    .TRAP_VECTOR (32'h0000_0100)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus.master)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic nxt();
    @(negedge clk);
  endtask

  initial begin
    checks = 0;
    errors = 0;
    reset_n         = 1'b0;
    bus.imem_ack    = 1'b0;
    bus.imem_rdata  = 32'h0;
    bus.stall       = 1'b0;
    bus.redirect    = 1'b0;
    bus.redirect_pc = 32'h0;
    bus.trap        = 1'b0;

    nxt(); nxt();
    chk("rst_req",   {31'b0, bus.imem_req},    32'h0);
    chk("rst_valid", {31'b0, bus.instr_valid}, 32'h0);
    chk("rst_pc",    bus.pc_out,               32'h0);
    chk("rst_instr", bus.instr,                32'h0);
    reset_n = 1'b1;

    // one IDLE cycle then first request
    nxt();
    chk("req0",  {31'b0, bus.imem_req}, 32'h1);
    chk("addr0", bus.imem_addr,         32'h0);
    bus.imem_ack = 1'b1; bus.imem_rdata = 32'hAAAA_0000;
    nxt();
    bus.imem_ack = 1'b0;
    chk("v0",     {31'b0, bus.instr_valid}, 32'h1);
    chk("ipc0",   bus.instr_pc,             32'h0);
    chk("instr0", bus.instr,                32'hAAAA_0000);
    chk("noreq0", {31'b0, bus.imem_req},    32'h0);
    nxt();
    chk("addr4", bus.imem_addr, 32'h4);
    bus.imem_ack = 1'b1; bus.imem_rdata = 32'hAAAA_0004;
    nxt();
    bus.imem_ack = 1'b0;
    chk("ipc4", bus.instr_pc, 32'h4);
    nxt();
    chk("addr8", bus.imem_addr, 32'h8);
    bus.imem_ack = 1'b1; bus.imem_rdata = 32'hAAAA_0008;
    nxt();
    bus.imem_ack = 1'b0;
    chk("ipc8", bus.instr_pc, 32'h8);
    bus.stall = 1'b1;

    // stall holds the instruction and suppresses requests
    for (int i = 0; i < 3; i++) begin
      nxt();
      chk("stall_v",     {31'b0, bus.instr_valid}, 32'h1);
      chk("stall_ipc",   bus.instr_pc,             32'h8);
      chk("stall_instr", bus.instr,                32'hAAAA_0008);
      chk("stall_req",   {31'b0, bus.imem_req},    32'h0);
    end
    bus.stall = 1'b0;
    nxt();
    chk("post_stall_addr", bus.imem_addr, 32'hC);

    // slow memory, redirect during wait cycle 2
    nxt();
    chk("wait_addr2", bus.imem_addr, 32'hC);
    bus.redirect = 1'b1; bus.redirect_pc = 32'h203;
    nxt();
    bus.redirect = 1'b0;
    chk("wait_addr3", bus.imem_addr, 32'hC);
    nxt();
    chk("wait_addr4", bus.imem_addr, 32'hC);
    bus.imem_ack = 1'b1; bus.imem_rdata = 32'hDEAD_BEEF;
    nxt();
    bus.imem_ack = 1'b0;
    chk("discard_v",  {31'b0, bus.instr_valid}, 32'h0);
    chk("redir_req",  {31'b0, bus.imem_req},    32'h1);
    chk("redir_addr", bus.imem_addr,            32'h200);
    bus.imem_ack = 1'b1; bus.imem_rdata = 32'h1234_0200;
    nxt();
    bus.imem_ack = 1'b0;
    chk("redir_ipc",   bus.instr_pc, 32'h200);
    chk("redir_instr", bus.instr,    32'h1234_0200);

    // trap beats redirect in VALID
    bus.trap = 1'b1; bus.redirect = 1'b1; bus.redirect_pc = 32'h40;
    nxt();
    bus.trap = 1'b0; bus.redirect = 1'b0;
    chk("trap_addr", bus.imem_addr,            32'h100);
    chk("trap_v",    {31'b0, bus.instr_valid}, 32'h0);
    chk("trap_req",  {31'b0, bus.imem_req},    32'h1);

    // two redirects in one outstanding request: newest wins
    bus.redirect = 1'b1; bus.redirect_pc = 32'h80;
    nxt();
    bus.redirect_pc = 32'hC0;
    nxt();
    bus.redirect = 1'b0;
    chk("dbl_hold", bus.imem_addr, 32'h100);
    bus.imem_ack = 1'b1; bus.imem_rdata = 32'h5555_5555;
    nxt();
    bus.imem_ack = 1'b0;
    chk("dbl_addr", bus.imem_addr,            32'hC0);
    chk("dbl_v",    {31'b0, bus.instr_valid}, 32'h0);
    bus.imem_ack = 1'b1; bus.imem_rdata = 32'h0000_00C0;
    nxt();
    bus.imem_ack = 1'b0;
    chk("dbl_ipc", bus.instr_pc, 32'hC0);

    // wrap: low bits of redirect_pc are masked, pc+4 wraps to 0
    bus.redirect = 1'b1; bus.redirect_pc = 32'hFFFF_FFFF;
    nxt();
    bus.redirect = 1'b0;
    chk("wrap_addr", bus.imem_addr, 32'hFFFF_FFFC);
    bus.imem_ack = 1'b1; bus.imem_rdata = 32'h7777_7777;
    nxt();
    bus.imem_ack = 1'b0;
    chk("wrap_ipc", bus.instr_pc, 32'hFFFF_FFFC);
    nxt();
    chk("wrap_next", bus.imem_addr, 32'h0);
    bus.imem_ack = 1'b1; bus.imem_rdata = 32'h1;
    nxt();
    bus.imem_ack = 1'b0;
    nxt();
    chk("pre_rst_addr", bus.imem_addr, 32'h4);

    // async reset mid-request, then an ack while IDLE is ignored
    #2 reset_n = 1'b0;
    #1;
    chk("arst_req", {31'b0, bus.imem_req},    32'h0);
    chk("arst_pc",  bus.pc_out,               32'h0);
    chk("arst_v",   {31'b0, bus.instr_valid}, 32'h0);
    nxt();
    bus.imem_ack = 1'b1; bus.imem_rdata = 32'h9999_9999;
    reset_n = 1'b1;
    nxt();
    bus.imem_ack = 1'b0;
    chk("idle_ack_req",  {31'b0, bus.imem_req},    32'h1);
    chk("idle_ack_addr", bus.imem_addr,            32'h0);
    chk("idle_ack_v",    {31'b0, bus.instr_valid}, 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
